// File: rtl/bit_util_pkg.sv
// Shared bit-manipulation definitions used by the bit index streamer and popcount blocks.
package bit_util_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Bits needed to address any bit of a w-bit word (at least one).
    function automatic int idx_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit, plus an any-set flag.
module lowest_set_bit
    import bit_util_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int IDXW = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit overwrites everything above it.
    always_comb begin
        idx = {IDXW{1'b0}};
        any = |vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx = vec[i] ? IDXW'(i) : idx;
        end
    end

endmodule

// File: rtl/bit_index_streamer.sv
// Expands one word into a stream of set-bit indices, lowest first, with a 1-based ordinal per beat.
module bit_index_streamer
    import bit_util_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int IDXW = idx_width(WIDTH),
    localparam int CNTW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic [CNTW-1:0]  out_count,
    output logic             out_none,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_mask;
    logic              r_none;
    logic [CNTW-1:0]   r_ordinal;

    logic [WIDTH-1:0]  w_mask_dec;
    logic [WIDTH-1:0]  w_mask_clr;
    logic [IDXW-1:0]   w_low_idx;
    logic              w_any;
    logic              w_last;
    logic              w_accept;
    logic              w_fire;

    lowest_set_bit #(
        .WIDTH (WIDTH)
    ) u_lsb (
        .vec (r_mask),
        .idx (w_low_idx),
        .any (w_any)
    );

    // mask & (mask-1) is only meaningful while mask is non-zero; the none flag covers the empty word.
    assign w_mask_dec = r_mask - {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_mask_clr = r_mask & w_mask_dec;
    assign w_last     = r_none || (w_mask_clr == {WIDTH{1'b0}});
    assign w_accept   = in_valid && in_ready;
    assign w_fire     = out_valid && out_ready;

    // Next-state and handshake/beat outputs; everything is zero outside BUSY.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_idx     = {IDXW{1'b0}};
        out_count   = {CNTW{1'b0}};
        out_none    = 1'b0;
        out_last    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                out_valid = 1'b1;
                out_idx   = w_any ? w_low_idx : {IDXW{1'b0}};
                out_count = r_none ? {CNTW{1'b0}} : r_ordinal;
                out_none  = r_none;
                out_last  = w_last;
                if (out_ready && w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Working mask, empty-word flag and running ordinal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask    <= {WIDTH{1'b0}};
            r_none    <= 1'b0;
            r_ordinal <= {CNTW{1'b0}};
        end else if (w_accept) begin
            r_mask    <= in_data;
            r_none    <= (in_data == {WIDTH{1'b0}});
            r_ordinal <= {{(CNTW-1){1'b0}}, 1'b1};
        end else if (w_fire) begin
            if (w_last) begin
                r_mask <= {WIDTH{1'b0}};
            end else begin
                r_mask    <= w_mask_clr;
                r_ordinal <= r_ordinal + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end else begin
            r_mask    <= r_mask;
            r_none    <= r_none;
            r_ordinal <= r_ordinal;
        end
    end

endmodule

// File: tb/tb_bit_index_streamer.sv
// Directed self-checking bench for bit_index_streamer (WIDTH=32).
module tb_bit_index_streamer;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  out_idx;
    logic [5:0]  out_count;
    logic        out_none;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    bit_index_streamer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_count (out_count),
        .out_none  (out_none),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idx"}, {27'd0, out_idx}, 32'd0);
        check({tag, "_count"}, {26'd0, out_count}, 32'd0);
        check({tag, "_none"}, {31'd0, out_none}, 32'd0);
        check({tag, "_last"}, {31'd0, out_last}, 32'd0);
    endtask

    task automatic check_beat(input string tag, input int idx, input int cnt,
                              input bit none, input bit last);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_idx"}, {27'd0, out_idx}, idx);
        check({tag, "_count"}, {26'd0, out_count}, cnt);
        check({tag, "_none"}, {31'd0, out_none}, {31'd0, none});
        check({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
    endtask

    // Presents one word for a single edge (block must be idle).
    task automatic send(input logic [31:0] word);
        in_data  = word;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int stall;
        rst       = 1'b1;
        in_data   = 32'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // Empty word: single beat, then idle.
        out_ready = 1'b1;
        send(32'h0000_0000);
        check_beat("zero", 0, 0, 1'b1, 1'b1);
        tick();
        check_idle("zero_after");

        // Sparse word including the top bit.
        send(32'h8000_0011);
        check_beat("sp0", 0, 1, 1'b0, 1'b0);
        tick();
        check_beat("sp1", 4, 2, 1'b0, 1'b0);
        tick();
        check_beat("sp2", 31, 3, 1'b0, 1'b1);
        tick();
        check_idle("sp_after");

        // All ones: 32 back-to-back beats, ordinal reaches WIDTH.
        send(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            check_beat($sformatf("ones%0d", i), i, i + 1, 1'b0, (i == 31));
            tick();
        end
        check_idle("ones_after");

        // Backpressure: outputs must hold across stalls.
        out_ready = 1'b0;
        send(32'h0000_0006);
        stall = $urandom_range(1, 3);
        for (int s = 0; s < stall; s++) begin
            check_beat($sformatf("stallA%0d", s), 1, 1, 1'b0, 1'b0);
            tick();
        end
        check_beat("stallA_go", 1, 1, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        stall = $urandom_range(1, 3);
        for (int s = 0; s < stall; s++) begin
            check_beat($sformatf("stallB%0d", s), 2, 2, 1'b0, 1'b1);
            tick();
        end
        check_beat("stallB_go", 2, 2, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        check_idle("stall_after");

        // Reset mid-stream discards the word at once.
        send(32'h0000_00F0);
        check_beat("rs0", 4, 1, 1'b0, 1'b0);
        tick();
        check_beat("rs1", 5, 2, 1'b0, 1'b0);
        tick();
        check_beat("rs2", 6, 3, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_idle("rs_async");
        tick();
        rst = 1'b0;
        tick();
        check_idle("rs_release");
        send(32'h0000_0001);
        check_beat("rs_one", 0, 1, 1'b0, 1'b1);
        tick();
        check_idle("rs_one_after");

        // Held in_valid: second copy accepted only in the idle cycle after the last beat.
        in_data  = 32'h0000_0003;
        in_valid = 1'b1;
        tick();
        check_beat("hv_a0", 0, 1, 1'b0, 1'b0);
        tick();
        check_beat("hv_a1", 1, 2, 1'b0, 1'b1);
        tick();
        check("hv_gap_valid", {31'd0, out_valid}, 32'd0);
        check("hv_gap_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_beat("hv_b0", 0, 1, 1'b0, 1'b0);
        tick();
        check_beat("hv_b1", 1, 2, 1'b0, 1'b1);
        tick();
        check_idle("hv_after");
        tick();
        check_idle("hv_quiet");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bit_index_streamer.md
Name: bit_index_streamer

Overview:
- Serial inverse of the team's combinational population counter: accepts one WIDTH-bit word and streams the index of every set bit, lowest first, one per handshake beat.
- Each beat carries a running 1-based ordinal, so the last beat's ordinal equals the word's popcount.
- Feeds sparse-mask consumers (scatter units, per-lane schedulers) that need indices rather than a bitmap.

Parameters:
- WIDTH, 32, input word width; power of two, >= 2.
- IDXW, $clog2(WIDTH) (localparam), width of the index output.
- CNTW, $clog2(WIDTH)+1 (localparam), width of the ordinal output; holds 0..WIDTH.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to expand.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word.
- out_idx  output  IDXW  bit index of the current beat.
- out_count  output  CNTW  1-based ordinal of the current beat; 0 on the empty beat.
- out_none  output  1  current beat reports an all-zero word.
- out_last  output  1  final beat for the current word.
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, mask=0, ordinal=0.
  - in_ready=1, out_valid=0, out_idx=0, out_count=0, out_none=0, out_last=0.
- States: IDLE, BUSY.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: mask<=in_data; none_flag<=(in_data==0); ordinal<=1; state<=BUSY.
- BUSY:
  - in_ready=0, out_valid=1.
  - Combinational outputs from registered mask:
    - out_idx = index of lowest set bit of mask (0 if mask==0).
    - out_last = none_flag || ((mask & (mask-1))==0).
    - out_none = none_flag.
    - out_count = none_flag ? 0 : ordinal.
  - On out_valid&&out_ready:
    - if out_last: state<=IDLE, mask<=0.
    - else: mask<=mask & (mask-1) (clears lowest set bit); ordinal<=ordinal+1.
  - Without out_ready, all outputs hold stable (AXI-style; no retraction or change while stalled).
- Latency and throughput:
  - A word accepted at edge N produces its first beat valid in the cycle after edge N.
  - A word with k set bits occupies k beats (1 beat if k=0), plus one IDLE cycle before the next accept.
  - Words do not overlap.
- Width rules:
  - ordinal never exceeds WIDTH; all-ones input gives out_count=WIDTH on the last beat, needing the CNTW extra bit.
  - mask-1 is computed at WIDTH bits; it is only used when mask!=0.
- Boundaries:
  - in_data=0: exactly one beat (out_none=1, out_last=1, out_idx=0, out_count=0).
  - Single set bit: one beat with out_last=1.
  - Bit WIDTH-1 set: out_idx=WIDTH-1 with no wrap.
  - in_valid while BUSY is ignored; the upstream source holds it.
  - rst asserted mid-stream: the word is discarded immediately, outputs return to reset values, and no further beats of that word appear.

Decomposition:
- Shared package bit_util_pkg holds:
  - the state enum (IDLE, BUSY);
  - the DEFAULT_WIDTH=32 constant;
  - an index-width helper, also used by the popcount block.
- One sub-module, lowest_set_bit:
  - parameter WIDTH; input vec; outputs idx[IDXW] and any.
  - Purely combinational priority encoder, instanced once on mask.

Test Plan:
- Reset, then in_data=32'h0000_0000 with out_ready=1 -> exactly one beat {idx=0, count=0, none=1, last=1}; in_ready returns to 1 the cycle after.
- in_data=32'h8000_0011, out_ready=1 -> beats idx 0,4,31 with counts 1,2,3; last=1 only on idx 31; each beat lasts one cycle.
- in_data=32'hFFFF_FFFF -> 32 beats idx 0..31, counts 1..32, last=1 only on idx 31; in_ready=0 throughout.
- in_data=32'h0000_0006 with out_ready toggled randomly -> beats idx 1 then 2; outputs stable across every stall cycle; no beat duplicated or lost.
- Accept 32'h0000_00F0, then assert rst after beat idx 5 -> outputs go to reset values immediately; after release, accepting 32'h1 yields a single beat {idx=0, count=1, last=1}.
- Hold in_valid with in_data=32'h3 during BUSY -> second word accepted only in the IDLE cycle after the first word's last beat; total beats 4.
